// File: rtl/zap_uart_rx_mmio_pkg.sv
// Shared register offsets, STATUS bit indices and RX state encodings for the UART receiver.
package zap_uart_rx_mmio_pkg;

    localparam logic [31:0] OFF_DATA   = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;
    localparam logic [31:0] OFF_CTRL   = 32'd8;

    localparam int unsigned ST_NEMPTY = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_OVR    = 2;
    localparam int unsigned ST_FERR   = 3;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic ferr;
        logic ovr;
        logic full;
        logic nempty;
    } status_t;

endpackage

// File: rtl/zap_uart_rx_mmio_fifo.sv
// Synchronous byte FIFO; pointers carry one wrap bit so full and empty are distinguishable.
module zap_uart_rx_mmio_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full_c,
    output logic             empty_c,
    output logic [WIDTH-1:0] head_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_c  = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/zap_uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: synchroniser, RX FSM, byte FIFO, sticky flags and CTRL.
module zap_uart_rx_mmio
    import zap_uart_rx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'd6004,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx,
    input  logic [31:0] i_address,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [3:0]  i_ben,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_irq
);

    localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta;
    logic          rx_sync;
    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          ovr;
    logic          ferr;
    logic          ien;

    logic          sel_data;
    logic          sel_status;
    logic          sel_ctrl;
    logic          stop_tick_c;
    logic          push_c;
    logic          ferr_set_c;
    logic          ovr_set_c;
    logic          pop_c;
    logic          clr_c;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    status_t       status;
    logic          unused;

    assign unused = ^{i_ben[3:1], i_wr_data[31:4], i_wr_data[1]};

    assign sel_data   = (i_address == BASE_ADDR + OFF_DATA);
    assign sel_status = (i_address == BASE_ADDR + OFF_STATUS);
    assign sel_ctrl   = (i_address == BASE_ADDR + OFF_CTRL);

    // Two-flop synchroniser, idle-high so reset does not look like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    assign stop_tick_c = (state == RX_STOP) && (cnt == CNT_FULL);
    assign push_c      = stop_tick_c & rx_sync;
    assign ferr_set_c  = stop_tick_c & ~rx_sync;
    assign pop_c       = i_read_en & sel_data;
    assign clr_c       = i_write_en & sel_status & i_ben[0];
    assign ovr_set_c   = push_c & fifo_full & ~pop_c;

    // RX FSM: mid-bit sampling, start bit verified at half a bit time.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shift <= {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= rx_sync ? RX_IDLE : RX_BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_BREAK: begin
                    cnt <= '0;
                    if (rx_sync) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    zap_uart_rx_mmio_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (push_c),
        .push_data (shift),
        .pop       (pop_c),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty),
        .head_c    (fifo_head)
    );

    // Sticky flags: the set is assigned last so it wins over a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
            ien  <= 1'b0;
        end else begin
            if (clr_c && i_wr_data[ST_OVR])  ovr  <= 1'b0;
            if (clr_c && i_wr_data[ST_FERR]) ferr <= 1'b0;
            if (ovr_set_c)  ovr  <= 1'b1;
            if (ferr_set_c) ferr <= 1'b1;
            if (i_write_en && sel_ctrl && i_ben[0]) ien <= i_wr_data[0];
        end
    end

    assign status = '{ferr: ferr, ovr: ovr, full: fifo_full, nempty: ~fifo_empty};

    always_comb begin
        o_rd_data = '0;
        if (sel_data && !fifo_empty) o_rd_data = {24'd0, fifo_head};
        else if (sel_status)         o_rd_data = {28'd0, status};
        else if (sel_ctrl)           o_rd_data = {31'd0, ien};
    end

    assign o_irq = ien & ~fifo_empty;

endmodule

// File: tb/tb_zap_uart_rx_mmio.sv
// Self-checking bench for zap_uart_rx_mmio: bit-level UART driver plus expected-byte scoreboard.
module tb_zap_uart_rx_mmio;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] A_DATA   = 32'd6004;
    localparam logic [31:0] A_STATUS = 32'd6008;
    localparam logic [31:0] A_CTRL   = 32'd6012;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [31:0] address;
    logic        read_en;
    logic        write_en;
    logic [3:0]  ben;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    int          errors;
    int          checks;
    logic [7:0]  exp_q[$];
    logic [31:0] rd;

    zap_uart_rx_mmio #(
        .BASE_ADDR    (32'd6004),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx       (rx),
        .i_address  (address),
        .i_read_en  (read_en),
        .i_write_en (write_en),
        .i_ben      (ben),
        .i_wr_data  (wr_data),
        .o_rd_data  (rd_data),
        .o_irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; the scoreboard models FIFO capacity and only queues accepted bytes.
    task automatic send_byte(input logic [7:0] b);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(1'b1, CPB);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        idle(2);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        address = addr;
        read_en = 1'b1;
        #1 data = rd_data;
        @(negedge clk);
        read_en = 1'b0;
        address = 32'd0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        address  = addr;
        wr_data  = data;
        ben      = 4'hF;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        address  = 32'd0;
        wr_data  = 32'd0;
    endtask

    task automatic read_data_sb(input string tag);
        logic [31:0] exp;
        logic [31:0] got;
        exp = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'd0;
        bus_read(A_DATA, got);
        check(tag, got, exp);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        rx       = 1'b1;
        address  = 32'd0;
        read_en  = 1'b0;
        write_en = 1'b0;
        ben      = 4'h0;
        wr_data  = 32'd0;
        idle(3);
        rst = 1'b0;
        idle(2);

        check("reset_irq", 32'(irq), 32'd0);
        bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0);
        bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
        bus_read(32'd6016, rd); check("unmapped", rd, 32'h0);

        // Single byte round trip.
        send_byte(8'hA5);
        bus_read(A_STATUS, rd); check("t1_status_nempty", rd, 32'h1);
        read_data_sb("t1_data");
        bus_read(A_STATUS, rd); check("t1_status_empty", rd, 32'h0);

        // Short low glitch must not start a frame.
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 3 * CPB);
        bus_read(A_STATUS, rd); check("t2_glitch_status", rd, 32'h0);
        read_data_sb("t2_empty_read");

        // Overflow: five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        bus_read(A_STATUS, rd); check("t3_status_full_ovr", rd, 32'h7);
        for (int i = 0; i < 4; i++) read_data_sb($sformatf("t3_data%0d", i));
        read_data_sb("t3_empty_read");
        bus_read(A_STATUS, rd); check("t3_status_ovr_only", rd, 32'h4);
        bus_write(A_STATUS, 32'h4);
        bus_read(A_STATUS, rd); check("t3_ovr_cleared", rd, 32'h0);

        // Framing error: stop bit low, line held low.
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, CPB);
        drive_bit(1'b0, 40);
        bus_read(A_STATUS, rd); check("t4_ferr", rd, 32'h8);
        drive_bit(1'b0, 2 * CPB);
        bus_read(A_STATUS, rd); check("t4_break_hold", rd, 32'h8);
        drive_bit(1'b1, CPB);
        send_byte(8'h3C);
        bus_read(A_STATUS, rd); check("t4_status_after", rd, 32'h9);
        read_data_sb("t4_data");
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, rd); check("t4_ferr_cleared", rd, 32'h0);

        // Interrupt follows ien & nempty.
        bus_write(A_CTRL, 32'h1);
        bus_read(A_CTRL, rd); check("t5_ctrl", rd, 32'h1);
        check("t5_irq_idle", 32'(irq), 32'd0);
        send_byte(8'h55);
        check("t5_irq_high", 32'(irq), 32'd1);
        read_data_sb("t5_data");
        check("t5_irq_low", 32'(irq), 32'd0);

        // Reset mid-frame clears FIFO, flags and CTRL.
        send_byte(8'h77);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB);
        rst = 1'b1;
        rx  = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        check("t6_irq", 32'(irq), 32'd0);
        bus_read(A_STATUS, rd); check("t6_status", rd, 32'h0);
        bus_read(A_CTRL, rd);   check("t6_ctrl", rd, 32'h0);
        read_data_sb("t6_empty_read");
        send_byte(8'h9A);
        read_data_sb("t6_data");
        bus_read(A_STATUS, rd); check("t6_status_end", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
